parity_stream_check: RTL and testbench

PARITY_STREAM_CHECK -- requirements
Module: parity_stream_check

---
 rtl/parity_pkg.sv | 35 +++
 rtl/parity_word.sv | 22 ++
 rtl/parity_stream_check.sv | 111 +++++++++++
 tb/tb_parity_stream_check.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the parity stream checker: FSM state encoding,
// parity mode constants, the registered result bundle and the next-state rule.
package parity_pkg;

  // Frame tracking states (kept as plain constants for legacy compatibility)
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  // Parity mode selector values for odd_mode
  localparam logic MODE_EVEN = 1'b0;
  localparam logic MODE_ODD  = 1'b1;

  // Per-word result reported one cycle after acceptance
  typedef struct packed {
    logic valid;
    logic par_err;
    logic lrc_err;
    logic frame_end;
  } result_t;

  // Frame FSM transition for one clock edge. A last word always closes the
  // frame (and a single-word frame never leaves IDLE); any other accepted
  // word opens or continues a frame; an idle cycle changes nothing.
  function automatic logic [0:0] next_state(input logic [0:0] cur,
                                            input logic       valid,
                                            input logic       last);
    logic [0:0] nxt;
    nxt = cur;
    if (valid) begin
      nxt = last ? ST_IDLE : ST_FRAME;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/parity_word.sv
// Combinational single-word parity check: flags an error when the XOR of the
// data bits and the transmitted parity bit differs from the selected mode.
module parity_word
  import parity_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] data,
  input  logic              par,
  input  logic              odd_mode,
  output logic              err
);

  logic total;

  // Even mode expects the overall XOR to be 0, odd mode expects 1
  always_comb begin
    total = ^data ^ par;
    err   = (odd_mode == MODE_ODD) ? ~total : total;
  end

endmodule

// File: rtl/parity_stream_check.sv
// Streaming parity / LRC checker. Every accepted word gets a registered
// result one cycle later; frames are tracked so the last word's data can be
// compared against the XOR of all earlier words in the frame. Error words
// are counted (saturating) and latched into a sticky flag.
module parity_stream_check
  import parity_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              odd_mode,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  input  logic              in_last,
  output logic              out_valid,
  output logic              par_err,
  output logic              lrc_err,
  output logic              frame_end,
  output logic              err_flag,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [0:0]        state;
  logic [DATA_W-1:0] acc;
  result_t           res;

  logic              par_bad;
  logic [DATA_W-1:0] acc_ref;
  logic              lrc_bad;
  logic              word_err;

  parity_word #(
    .DATA_W (DATA_W)
  ) u_word (
    .data     (in_data),
    .par      (in_par),
    .odd_mode (odd_mode),
    .err      (par_bad)
  );

  // Evaluate the incoming word: LRC reference is zero outside a frame,
  // and only accepted words can be erroneous
  always_comb begin
    // NOTE: every signal written here gets a value on every path, so no latch is inferred.
    acc_ref  = (state == ST_FRAME) ? acc : '0;
    lrc_bad  = in_last && (in_data != acc_ref);
    word_err = in_valid && (par_bad || lrc_bad);
  end

  // Frame state and running LRC accumulator; gaps leave both untouched
  always_ff @(posedge clk or negedge n_rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!n_rst) begin
      state <= ST_IDLE;
      acc   <= '0;
    end else begin
      state <= next_state(state, in_valid, in_last);
      if (in_valid) begin
        if (in_last) begin
          acc <= '0;
        end else if (state == ST_IDLE) begin
          acc <= in_data;
        end else begin
          acc <= acc ^ in_data;
        end
      end
    end
  end

  // Registered per-word result, valid exactly one cycle after acceptance
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      res <= '0;
    end else begin
      res.valid     <= in_valid;
      res.par_err   <= in_valid && par_bad;
      res.lrc_err   <= in_valid && lrc_bad;
      res.frame_end <= in_valid && in_last;
    end
  end

  // Error bookkeeping: clr wipes history but the word registered at the same
  // edge still counts, so a clearing edge leaves either 0/0 or 1/1
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (clr) begin
      err_cnt  <= word_err ? CNT_ONE : '0;
      err_flag <= word_err;
    end else if (word_err) begin
      err_flag <= 1'b1;
      if (err_cnt != CNT_MAX) begin
        err_cnt <= err_cnt + CNT_ONE;
      end
    end
  end

  assign out_valid = res.valid;
  assign par_err   = res.par_err;
  assign lrc_err   = res.lrc_err;
  assign frame_end = res.frame_end;

endmodule

// File: tb/tb_parity_stream_check.sv
// Directed testbench for parity_stream_check with DATA_W=4, CNT_W=2.
module tb_parity_stream_check;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              n_rst;
  logic              odd_mode;
  logic              clr;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_par;
  logic              in_last;
  logic              out_valid;
  logic              par_err;
  logic              lrc_err;
  logic              frame_end;
  logic              err_flag;
  logic [CNT_W-1:0]  err_cnt;

  int total;
  int bad;

  parity_stream_check #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .odd_mode  (odd_mode),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_par    (in_par),
    .in_last   (in_last),
    .out_valid (out_valid),
    .par_err   (par_err),
    .lrc_err   (lrc_err),
    .frame_end (frame_end),
    .err_flag  (err_flag),
    .err_cnt   (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one word for exactly one rising edge, then sample its result
  task automatic send(input logic [DATA_W-1:0] d, input logic p,
                      input logic last, input logic mode, input logic c);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_par   = p;
    in_last  = last;
    odd_mode = mode;
    clr      = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    clr      = 1'b0;
  endtask

  // One clr-only cycle with no word
  task automatic pulse_clr();
    @(negedge clk);
    clr      = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    #3;
    total++;
    if ({out_valid, par_err, lrc_err, frame_end, err_flag} !== 5'b0) begin
      bad++;
      $display("FAIL reset_outputs: got %b want 00000",
               {out_valid, par_err, lrc_err, frame_end, err_flag});
    end
    total++;
    if (err_cnt !== 2'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d want 0", err_cnt);
    end
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_good_frame();
    logic [DATA_W-1:0] d [4];
    logic              p [4];
    d[0] = 4'b0100; p[0] = 1'b1;
    d[1] = 4'b0110; p[1] = 1'b0;
    d[2] = 4'b0111; p[2] = 1'b1;
    d[3] = 4'b0101; p[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(d[i], p[i], (i == 3), 1'b0, 1'b0);
      total++;
      if ({out_valid, par_err, lrc_err, frame_end} !== {1'b1, 1'b0, 1'b0, (i == 3)}) begin
        bad++;
        $display("FAIL good_frame_w%0d: got v/p/l/e=%b want %b", i,
                 {out_valid, par_err, lrc_err, frame_end}, {1'b1, 1'b0, 1'b0, (i == 3)});
      end
    end
    total++;
    if (err_cnt !== 2'd0 || err_flag !== 1'b0) begin
      bad++;
      $display("FAIL good_frame_cnt: got cnt=%0d flag=%b want 0/0", err_cnt, err_flag);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_valid: got %b want 0", out_valid);
    end
  endtask

  task automatic test_par_flip();
    logic [DATA_W-1:0] d [4];
    logic              p [4];
    d[0] = 4'b0100; p[0] = 1'b1;
    d[1] = 4'b0110; p[1] = 1'b1;
    d[2] = 4'b0111; p[2] = 1'b1;
    d[3] = 4'b0101; p[3] = 1'b0;
    pulse_clr();
    for (int i = 0; i < 4; i++) begin
      send(d[i], p[i], (i == 3), 1'b0, 1'b0);
      total++;
      if (par_err !== (i == 1) || lrc_err !== 1'b0) begin
        bad++;
        $display("FAIL par_flip_w%0d: got par=%b lrc=%b want par=%b lrc=0", i,
                 par_err, lrc_err, (i == 1));
      end
    end
    total++;
    if (err_cnt !== 2'd1 || err_flag !== 1'b1) begin
      bad++;
      $display("FAIL par_flip_cnt: got cnt=%0d flag=%b want 1/1", err_cnt, err_flag);
    end
  endtask

  task automatic test_lrc_bad();
    pulse_clr();
    send(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    send(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    send(4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
    send(4'b1111, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({par_err, lrc_err, frame_end} !== 3'b011) begin
      bad++;
      $display("FAIL lrc_bad: got p/l/e=%b want 011", {par_err, lrc_err, frame_end});
    end
    total++;
    if (err_cnt !== 2'd1) begin
      bad++;
      $display("FAIL lrc_bad_cnt: got %0d want 1", err_cnt);
    end
  endtask

  task automatic test_saturate();
    logic [CNT_W-1:0] exp_cnt [5];
    exp_cnt[0] = 2'd1; exp_cnt[1] = 2'd2; exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3; exp_cnt[4] = 2'd3;
    pulse_clr();
    for (int i = 0; i < 5; i++) begin
      send(4'b0001, 1'b0, 1'b0, 1'b0, 1'b0);
      total++;
      if (err_cnt !== exp_cnt[i] || par_err !== 1'b1) begin
        bad++;
        $display("FAIL saturate_%0d: got cnt=%0d par=%b want cnt=%0d par=1", i,
                 err_cnt, par_err, exp_cnt[i]);
      end
    end
    pulse_clr();
    total++;
    if (err_cnt !== 2'd0 || err_flag !== 1'b0) begin
      bad++;
      $display("FAIL saturate_clr: got cnt=%0d flag=%b want 0/0", err_cnt, err_flag);
    end
  endtask

  task automatic test_reset_midframe();
    send(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    send(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
    #2;
    n_rst = 1'b0;
    #1;
    total++;
    if ({out_valid, par_err, lrc_err, frame_end, err_flag, err_cnt} !== 7'b0) begin
      bad++;
      $display("FAIL midframe_reset: got %b want 0000000",
               {out_valid, par_err, lrc_err, frame_end, err_flag, err_cnt});
    end
    @(negedge clk);
    n_rst = 1'b1;
    send(4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if ({out_valid, par_err, lrc_err, frame_end} !== 4'b1001) begin
      bad++;
      $display("FAIL midframe_single: got v/p/l/e=%b want 1001",
               {out_valid, par_err, lrc_err, frame_end});
    end
  endtask

  task automatic test_odd_mode();
    send(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
    total++;
    if (par_err !== 1'b0 || lrc_err !== 1'b0) begin
      bad++;
      $display("FAIL odd_good: got par=%b lrc=%b want 0/0", par_err, lrc_err);
    end
    send(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (par_err !== 1'b1 || err_cnt !== 2'd1) begin
      bad++;
      $display("FAIL odd_bad: got par=%b cnt=%0d want 1/1", par_err, err_cnt);
    end
  endtask

  task automatic test_clr_collision();
    // Count is 1 here; an erroneous word with clr restarts at 1
    send(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    send(4'b0001, 1'b0, 1'b1, 1'b0, 1'b1);
    total++;
    if (err_cnt !== 2'd1 || err_flag !== 1'b1) begin
      bad++;
      $display("FAIL clr_err_word: got cnt=%0d flag=%b want 1/1", err_cnt, err_flag);
    end
    send(4'b0011, 1'b0, 1'b0, 1'b0, 1'b1);
    total++;
    if (err_cnt !== 2'd0 || err_flag !== 1'b0) begin
      bad++;
      $display("FAIL clr_good_word: got cnt=%0d flag=%b want 0/0", err_cnt, err_flag);
    end
    send(4'b0011, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_gap_mode_change();
    send(4'b0100, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL gap_valid: got %b want 0", out_valid);
    end
    send(4'b0110, 1'b1, 1'b0, 1'b1, 1'b0);
    total++;
    if (par_err !== 1'b0) begin
      bad++;
      $display("FAIL gap_odd_word: got par=%b want 0", par_err);
    end
    @(posedge clk);
    send(4'b0010, 1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if ({out_valid, par_err, lrc_err, frame_end} !== 4'b1001 || err_cnt !== 2'd0) begin
      bad++;
      $display("FAIL gap_last: got v/p/l/e=%b cnt=%0d want 1001 cnt=0",
               {out_valid, par_err, lrc_err, frame_end}, err_cnt);
    end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    odd_mode = 1'b0;
    clr      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_par   = 1'b0;
    in_last  = 1'b0;
    test_reset();
    test_good_frame();
    test_par_flip();
    test_lrc_bad();
    test_saturate();
    test_reset_midframe();
    test_odd_mode();
    test_clr_collision();
    test_gap_mode_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
